// File: rtl/mux_serializer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module      : mux_serializer_pkg                                      |
// | Description : Shared widths, FSM state type and index helpers for     |
// |               the 16-bit mux serializer.                              |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
package mux_serializer_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Index of the first bit streamed for a given bit order.
    function automatic logic [SEL_W-1:0] start_sel(input int msb_first);
        return (msb_first != 0) ? SEL_W'(DATA_W - 1) : '0;
    endfunction

    // Index of the final bit streamed for a given bit order.
    function automatic logic [SEL_W-1:0] end_sel(input int msb_first);
        return (msb_first != 0) ? '0 : SEL_W'(DATA_W - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_16x1.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module      : mux_16x1                                                |
// | Description : 16-to-1 single-bit multiplexer.                         |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module mux_16x1
    import mux_serializer_pkg::*;
(
    input  logic [DATA_W-1:0] i,
    input  logic [SEL_W-1:0]  s,
    output logic              out
);

    assign out = i[s];

endmodule
`default_nettype wire

// File: rtl/mux_serializer_16.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module      : mux_serializer_16                                       |
// | Description : Accepts a 16-bit word in IDLE and streams it one bit    |
// |               per valid/ready beat through a 16:1 mux.                |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module mux_serializer_16
    import mux_serializer_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_out,
    output logic [SEL_W-1:0]  sel,
    output logic              last
);

    localparam logic [SEL_W-1:0] C_START = start_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] C_END   = end_sel(MSB_FIRST);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [SEL_W-1:0]  w_sel_step;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sel_step = r_sel - SEL_W'(1);
        end else begin : g_lsb_first
            assign w_sel_step = r_sel + SEL_W'(1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_sel   <= C_START;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // Data only loads in IDLE, so in_valid during SHIFT is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = in_data;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    if (r_sel == C_END) begin
                        w_state_nxt = IDLE;
                        w_sel_nxt   = C_START;
                    end else begin
                        w_sel_nxt   = w_sel_step;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = C_START;
            end
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign ser_valid = (r_state == SHIFT);
    assign last      = (r_state == SHIFT) && (r_sel == C_END);
    assign sel       = r_sel;

    mux_16x1 u_mux (
        .i   (r_data),
        .s   (r_sel),
        .out (ser_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_mux_serializer_16.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module      : tb_mux_serializer_16                                    |
// | Description : Self-checking bench for mux_serializer_16, both orders. |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module tb_mux_serializer_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid0, ser_ready0, in_valid1, ser_ready1;
    logic [15:0] in_data0, in_data1;
    logic        in_ready0, ser_valid0, ser_out0, last0;
    logic        in_ready1, ser_valid1, ser_out1, last1;
    logic [3:0]  sel0, sel1;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    mux_serializer_16 #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .ser_ready(ser_ready0), .ser_valid(ser_valid0),
        .ser_out(ser_out0), .sel(sel0), .last(last0)
    );

    mux_serializer_16 #(.MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .ser_ready(ser_ready1), .ser_valid(ser_valid1),
        .ser_out(ser_out1), .sel(sel1), .last(last1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        in_valid0 = 1'b0; ser_ready0 = 1'b0; in_data0 = 16'h1234;
        in_valid1 = 1'b0; ser_ready1 = 1'b0; in_data1 = 16'h4321;
        tick();
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        checks++;
        if ({in_ready0, ser_valid0, ser_out0, last0, sel0} !== exp)
            $display("FAIL reset_lsb: got %b want %b", {in_ready0, ser_valid0, ser_out0, last0, sel0}, exp);
        else passes++;
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd15};
        checks++;
        if ({in_ready1, ser_valid1, ser_out1, last1, sel1} !== exp)
            $display("FAIL reset_msb: got %b want %b", {in_ready1, ser_valid1, ser_out1, last1, sel1}, exp);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_lsb_single();
        logic [7:0] exp;
        in_data0 = 16'h0001; in_valid0 = 1'b1; ser_ready0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = {1'b0, 1'b1, (k == 0), (k == 15), 4'(k)};
            checks++;
            if ({in_ready0, ser_valid0, ser_out0, last0, sel0} !== exp)
                $display("FAIL lsb_beat%0d: got %b want %b", k, {in_ready0, ser_valid0, ser_out0, last0, sel0}, exp);
            else passes++;
            tick();
        end
        checks++;
        if ({in_ready0, ser_valid0, last0, sel0} !== {1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL lsb_idle_after: got %b want %b", {in_ready0, ser_valid0, last0, sel0}, {1'b1, 1'b0, 1'b0, 4'd0});
        else passes++;
    endtask

    task automatic test_msb_first();
        logic [15:0] word;
        logic [7:0]  exp;
        int          s;
        word = 16'hA5C3;
        in_data1 = word; in_valid1 = 1'b1; ser_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s = 15 - k;
            exp = {1'b0, 1'b1, word[s], (k == 15), 4'(s)};
            checks++;
            if ({in_ready1, ser_valid1, ser_out1, last1, sel1} !== exp)
                $display("FAIL msb_beat%0d: got %b want %b", k, {in_ready1, ser_valid1, ser_out1, last1, sel1}, exp);
            else passes++;
            tick();
        end
        checks++;
        if ({in_ready1, ser_valid1, sel1} !== {1'b1, 1'b0, 4'd15})
            $display("FAIL msb_idle_after: got %b want %b", {in_ready1, ser_valid1, sel1}, {1'b1, 1'b0, 4'd15});
        else passes++;
    endtask

    task automatic test_stall();
        int cyc = 0;
        int stalls = 0;
        bit prev_stall = 1'b0;
        in_data0 = 16'hFFFF; in_valid0 = 1'b1; ser_ready0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        while (ser_valid0 && cyc < 40) begin
            cyc++;
            if (prev_stall) begin
                checks++;
                if ({sel0, ser_out0} !== {4'd5, 1'b1})
                    $display("FAIL stall_hold: got sel=%0d out=%b want sel=5 out=1", sel0, ser_out0);
                else passes++;
            end
            if (sel0 == 4'd5 && stalls < 3) begin
                ser_ready0 = 1'b0; stalls++; prev_stall = 1'b1;
            end else begin
                ser_ready0 = 1'b1; prev_stall = 1'b0;
            end
            tick();
        end
        ser_ready0 = 1'b1;
        checks++;
        if (cyc != 19) $display("FAIL stall_shift_cycles: got %0d want 19", cyc);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int          cyc = 0;
        int          accepts = 0;
        int          done = 0;
        int          second_cyc = 0;
        logic [15:0] beat_word = '0;
        logic [15:0] exp;
        sb_q.delete();
        in_data0 = 16'h8000; in_valid0 = 1'b1; ser_ready0 = 1'b1;
        while (done < 2 && cyc < 100) begin
            cyc++;
            if (ser_valid0 && ser_ready0) begin
                beat_word[sel0] = ser_out0;
                if (last0) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL b2b_word: got %h want <none queued>", beat_word);
                    end else begin
                        exp = sb_q.pop_front();
                        if (beat_word !== exp) $display("FAIL b2b_word: got %h want %h", beat_word, exp);
                        else passes++;
                    end
                    done++;
                end
            end
            if (in_ready0 && in_valid0) begin
                sb_q.push_back(in_data0);
                accepts++;
                if (accepts == 2) second_cyc = cyc;
            end
            tick();
            if (accepts >= 1) in_data0 = 16'h0001;
            if (accepts >= 2) in_valid0 = 1'b0;
        end
        in_valid0 = 1'b0;
        checks++;
        if (cyc != 34) $display("FAIL b2b_total_cycles: got %0d want 34", cyc);
        else passes++;
        checks++;
        if (second_cyc != 18) $display("FAIL b2b_second_accept: got cycle %0d want 18", second_cyc);
        else passes++;
    endtask

    task automatic test_reset_abort();
        int          cyc = 0;
        logic [15:0] word;
        in_data0 = 16'h00FF; in_valid0 = 1'b1; ser_ready0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        while (sel0 != 4'd7 && cyc < 20) begin
            cyc++;
            tick();
        end
        checks++;
        if ({ser_valid0, sel0} !== {1'b1, 4'd7})
            $display("FAIL abort_reach_sel7: got valid=%b sel=%0d want valid=1 sel=7", ser_valid0, sel0);
        else passes++;
        rst = 1'b1;
        in_valid0 = 1'b1;
        tick();
        rst = 1'b0;
        in_valid0 = 1'b0;
        checks++;
        if ({in_ready0, ser_valid0, last0, sel0} !== {1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL abort_after_rst: got %b want %b", {in_ready0, ser_valid0, last0, sel0}, {1'b1, 1'b0, 1'b0, 4'd0});
        else passes++;
        tick();
        checks++;
        if (ser_valid0 !== 1'b0) $display("FAIL abort_no_beats: got ser_valid=%b want 0", ser_valid0);
        else passes++;
        word = 16'h0003;
        in_data0 = word; in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({ser_valid0, sel0, ser_out0} !== {1'b1, 4'(k), word[k]})
                $display("FAIL abort_next_beat%0d: got valid=%b sel=%0d out=%b want 1 %0d %b",
                         k, ser_valid0, sel0, ser_out0, k, word[k]);
            else passes++;
            tick();
        end
    endtask

    task automatic test_random();
        int          cyc = 0;
        int          n_sent = 0;
        int          n_done = 0;
        int          bidx = 0;
        logic [15:0] beat_word = '0;
        logic [15:0] exp;
        sb_q.delete();
        while (n_done < 200 && cyc < 20000) begin
            cyc++;
            in_valid0  = (n_sent < 200) && ($urandom_range(0, 3) != 0);
            in_data0   = 16'($urandom);
            ser_ready0 = 1'($urandom_range(0, 1));
            if (ser_valid0 && ser_ready0) begin
                checks++;
                if ({sel0, last0} !== {4'(bidx), (bidx == 15)})
                    $display("FAIL rand_beat_index: got sel=%0d last=%b want sel=%0d last=%b",
                             sel0, last0, bidx, (bidx == 15));
                else passes++;
                beat_word[sel0] = ser_out0;
                bidx++;
                if (last0) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        $display("FAIL rand_word: got %h want <none queued>", beat_word);
                    end else begin
                        exp = sb_q.pop_front();
                        if (beat_word !== exp) $display("FAIL rand_word%0d: got %h want %h", n_done, beat_word, exp);
                        else passes++;
                    end
                    n_done++;
                    bidx = 0;
                end
            end
            if (in_ready0 && in_valid0) begin
                sb_q.push_back(in_data0);
                n_sent++;
            end
            tick();
        end
        in_valid0 = 1'b0;
        checks++;
        if (n_done != 200) $display("FAIL rand_completed: got %0d words want 200", n_done);
        else passes++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lsb_single();
        test_msb_first();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_serializer_16.md
MUX_SERIALIZER_16 -- requirements
Module: mux_serializer_16

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 0: 0 streams bit 0 first, 1 streams bit 15 first.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, which indicates that in_data holds a word.
REQ-005 SHALL have port in_data, input, 16, the parallel word to serialize.
REQ-006 SHALL have port in_ready, output, 1, high when a word can be accepted.
REQ-007 SHALL have port ser_ready, input, 1, downstream accept of the current bit.
REQ-008 SHALL have port ser_valid, output, 1, high when ser_out carries a valid bit.
REQ-009 SHALL have port ser_out, output, 1, the current serial bit.
REQ-010 SHALL have port sel, output, 4, the bit index currently selected.
REQ-011 SHALL have port last, output, 1, high with the final bit of a word.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-013 IDLE: in_ready=1, ser_valid=0, last=0, and sel holds the start index (0 if MSB_FIRST=0, 15 if MSB_FIRST=1).
REQ-014 In IDLE, when in_valid=1 the block SHALL register in_data into a 16-bit data register, then enter SHIFT on the next edge.
REQ-015 SHIFT: in_ready=0 and ser_valid=1, with ser_out = data[sel] taken combinationally through the mux from registers, so no extra latency.
REQ-016 A beat SHALL complete only on a cycle where ser_valid=1 and ser_ready=1; sel then steps +1 if MSB_FIRST=0, or -1 if MSB_FIRST=1.
REQ-017 While ser_ready=0, sel, ser_out, the data register and the state SHALL hold unchanged.
REQ-018 last SHALL be 1 exactly when state=SHIFT and sel equals the end index (15 if MSB_FIRST=0, 0 if MSB_FIRST=1).
REQ-019 When the last beat completes, the FSM SHALL return to IDLE and reload sel with the start index; sel SHALL never wrap within a word.
REQ-020 When in_valid=1 during SHIFT, the block SHALL ignore the input and keep the data register unchanged.
REQ-021 A new word SHALL be accepted only in IDLE, so minimum throughput is 17 cycles per word (16 beats plus 1 idle cycle).
REQ-022 in_ready SHALL be a pure function of the state and SHALL NOT depend combinationally on in_valid.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL set state=IDLE, data=16'h0000 and sel=start index.
REQ-024 Outputs after reset SHALL be in_ready=1, ser_valid=0, ser_out=0 and last=0.
REQ-025 Reset during SHIFT SHALL abort the word with no further beats; the next accepted word SHALL stream from the start index.
REQ-026 rst SHALL take priority over in_valid and ser_ready in the same cycle.

Structure
REQ-027 Package mux_serializer_pkg SHALL hold the state typedef (IDLE, SHIFT), DATA_W=16 and SEL_W=4.
REQ-028 Bit selection SHALL use one instance of sub-module mux_16x1 (ports i[15:0], s[3:0], out), with i=data register, s=sel and out=ser_out.
REQ-029 All state SHALL be held in a single clocked process; the next-state and last logic SHALL be combinational.

Verification
REQ-030 Reset, then in_data=16'h0001 with MSB_FIRST=0 and ser_ready=1: ser_out=1 at sel=0, then 0 for sel=1..15; last=1 only at sel=15; in_ready=1 on the next cycle.
REQ-031 MSB_FIRST=1 with in_data=16'hA5C3: ser_out sequence 1010_0101_1100_0011, with sel counting 15 down to 0.
REQ-032 in_data=16'hFFFF with ser_ready=0 for 3 cycles at sel=5: sel stays 5 and ser_out stays 1 during the stall; the word completes in 19 SHIFT cycles.
REQ-033 in_valid held high with 16'h8000 then 16'h0001: the second word is ignored during SHIFT and accepted in IDLE; both words take 34 cycles total.
REQ-034 rst pulsed at sel=7 of 16'h00FF: the next cycle shows ser_valid=0, in_ready=1 and sel=0; a following word 16'h0003 streams from bit 0 correctly.
REQ-035 Self-checking scoreboard: reconstruct each word from ser_out/sel beats and compare it with the accepted in_data over 200 random words with random ser_ready.
